// File: rtl/servo_pkg.sv
// Shared constants, types and the angle-to-pulse-width helper for the servo
// pose sequencer and its frame timer.
package servo_pkg;

    localparam logic [31:0] MIN_DUTY            = 32'd35000;
    localparam logic [31:0] DUTY_PER_DEG        = 32'd500;
    localparam logic [7:0]  MAX_ANGLE           = 8'd180;
    localparam logic [31:0] PARK_DUTY           = 32'd80000;
    localparam int          DEFAULT_FRAME_TICKS = 1000001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] angle;
        logic [7:0] dwell;
    } pose_t;

    // Out-of-range angles saturate at the mechanical end stop.
    function automatic logic [31:0] angle_to_duty(input logic [7:0] angle);
        logic [7:0] a;
        a = (angle > MAX_ANGLE) ? MAX_ANGLE : angle;
        return MIN_DUTY + ({24'd0, a} * DUTY_PER_DEG);
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running frame counter; emits a one-cycle strobe while the count sits at
// FRAME_TICKS-1 so playback stays in phase with the downstream PWM period.
module servo_frame_timer #(
    parameter int FRAME_TICKS = 1000001
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = $clog2(FRAME_TICKS);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Counter wraps after FRAME_TICKS-1; the strobe is pre-decoded one count early.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            if (cnt_r == CW'(FRAME_TICKS - 1)) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            tick_r <= (cnt_r == CW'(FRAME_TICKS - 2));
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/servo_pose_sequencer.sv
// Pose table plus playback FSM feeding the servo PWM generator's duty input.
// Poses are written while idle and replayed one per dwell period of frame ticks.
module servo_pose_sequencer
    import servo_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int FRAME_TICKS = DEFAULT_FRAME_TICKS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [7:0]               wr_angle,
    input  logic [7:0]               wr_dwell,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    output logic [31:0]              duty,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] pose_idx,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   pose_idx_r, idx_s;
    logic [CNT_W-1:0]   count_r, count_s;
    logic [7:0]         dwell_r, dwell_s;
    logic [31:0]        duty_r, duty_s;
    logic               done_r, done_s;
    logic               busy_r;
    logic               tick_s;
    logic               wr_ready_s, wr_fire_s, last_s;
    pose_t              cur_s;
    pose_t              table_r [DEPTH];

    servo_frame_timer #(.FRAME_TICKS(FRAME_TICKS)) u_frame_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    // Write handshake, table occupancy and playback next-state logic.
    always_comb begin
        state_s    = state_r;
        idx_s      = pose_idx_r;
        dwell_s    = dwell_r;
        duty_s     = duty_r;
        done_s     = 1'b0;
        count_s    = count_r;
        cur_s      = table_r[pose_idx_r];
        last_s     = ({1'b0, pose_idx_r} == (count_r - CNT_W'(1)));
        wr_ready_s = (state_r == IDLE) && (count_r < CNT_W'(DEPTH)) && !clear;
        wr_fire_s  = wr_valid && wr_ready_s;

        if ((state_r == IDLE) && clear) begin
            count_s = '0;
        end else if (wr_fire_s) begin
            count_s = count_r + CNT_W'(1);
        end else begin
            count_s = count_r;
        end

        case (state_r)
            IDLE: begin
                if (stop) begin
                    state_s = IDLE;
                end else if (start && (count_r != '0)) begin
                    state_s = LOAD;
                    idx_s   = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (stop) begin
                    state_s = IDLE;
                end else begin
                    duty_s  = angle_to_duty(cur_s.angle);
                    dwell_s = (cur_s.dwell == 8'd0) ? 8'd1 : cur_s.dwell;
                    state_s = DWELL;
                end
            end
            DWELL: begin
                if (stop) begin
                    state_s = IDLE;
                end else if (tick_s) begin
                    // loop_en is looked at only here, so it may change mid-playback.
                    if (dwell_r != 8'd1) begin
                        dwell_s = dwell_r - 8'd1;
                    end else if (!last_s) begin
                        idx_s   = pose_idx_r + IDX_W'(1);
                        state_s = LOAD;
                    end else if (loop_en) begin
                        idx_s   = '0;
                        state_s = LOAD;
                    end else begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = DWELL;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Pose table storage; only entries below count_r hold meaningful data.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            table_r[count_r[IDX_W-1:0]] <= {wr_angle, wr_dwell};
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            pose_idx_r <= '0;
            count_r    <= '0;
            dwell_r    <= 8'd0;
            duty_r     <= PARK_DUTY;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            pose_idx_r <= idx_s;
            count_r    <= count_s;
            dwell_r    <= dwell_s;
            duty_r     <= duty_s;
            done_r     <= done_s;
            busy_r     <= (state_s != IDLE);
        end
    end

    assign wr_ready = wr_ready_s;
    assign duty     = duty_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign pose_idx = pose_idx_r;
    assign count    = count_r;

endmodule
